// File: rtl/encoder8_3_deb.sv
// encoder8_3_deb: debounced 8-to-3 priority encoder with valid/ready output.
// Eight raw lines are synchronised, debounced as one pattern, and each new
// stable non-zero pattern is reported as the index of its highest set bit.
// Ports:
//   sys_clk    in   system clock (rising edge)
//   sys_rst    in   asynchronous active-high reset
//   in[7:0]    in   raw asynchronous lines, bit 7 highest priority
//   out_ready  in   consumer accepts the pending event
//   out_valid  out  event pending, held until accepted
//   code[2:0]  out  index of highest set bit of committed pattern
//   multi      out  committed pattern had more than one bit set
//   overrun    out  pending event overwritten before acceptance (sticky)
module encoder8_3_deb #(
  parameter int unsigned CNT_MAX = 999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] code,
  output logic       multi,
  output logic       overrun
);

  localparam logic [19:0] CMAX = 20'(CNT_MAX);

  typedef enum logic {
    S_IDLE,
    S_SETTLE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_in_s1;
  logic [7:0]  r_in_s2;
  logic [7:0]  r_stable;
  logic [7:0]  r_cand;
  logic [19:0] r_cnt;
  logic        r_valid;
  logic [2:0]  r_code;
  logic        r_multi;
  logic        r_overrun;

  logic        w_load;
  logic        w_inc;
  logic        w_commit;
  logic        w_event;
  logic [2:0]  w_code;
  logic        w_multi;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_in_s1 <= '0;
      r_in_s2 <= '0;
    end else begin
      r_in_s1 <= in;
      r_in_s2 <= r_in_s1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (r_in_s2 != r_stable) w_next = S_SETTLE;
      S_SETTLE:
        if (r_in_s2 == r_cand && r_cnt == CMAX)
          w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_inc    = 1'b0;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE:
        w_load = (r_in_s2 != r_stable);
      S_SETTLE:
        if (r_in_s2 != r_cand) w_load = 1'b1;
        else if (r_cnt == CMAX) w_commit = 1'b1;
        else w_inc = 1'b1;
    endcase
  end

  // Release to zero or return to the old pattern commits silently.
  assign w_event = w_commit && (r_cand != 8'h00)
                 && (r_cand != r_stable);

  always_comb begin
    w_code = 3'd0;
    for (int i = 0; i < 8; i++)
      if (r_cand[i]) w_code = 3'(i);
  end

  // Clearing the lowest set bit leaves something iff two or more were set.
  assign w_multi = |(r_cand & (r_cand - 8'd1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      if (w_load) begin
        r_cand <= r_in_s2;
        r_cnt  <= '0;
      end else if (w_inc) begin
        r_cnt <= r_cnt + 20'd1;
      end
      if (w_commit) r_stable <= r_cand;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_valid   <= 1'b0;
      r_code    <= 3'd0;
      r_multi   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_event) begin
      r_valid   <= 1'b1;
      r_code    <= w_code;
      r_multi   <= w_multi;
      // A same-edge transfer frees the slot, so no overrun then.
      r_overrun <= r_valid & ~out_ready;
    end else if (r_valid && out_ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign code      = r_code;
  assign multi     = r_multi;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_encoder8_3_deb.sv
// tb_encoder8_3_deb: directed and random checks of encoder8_3_deb
// against a run-length reference model, CNT_MAX = 3.
module tb_encoder8_3_deb;

  localparam int CM = 3;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] in;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] code;
  logic       multi;
  logic       overrun;

  int n_vec;
  int n_err;

  logic [7:0] m_s1, m_s2, m_stable, m_run_val;
  int         m_run_len;
  logic       m_valid, m_multi, m_ovr;
  logic [2:0] m_code;

  encoder8_3_deb #(.CNT_MAX(CM)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in       (in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .code     (code),
    .multi    (multi),
    .overrun  (overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00;
    m_run_val = 8'h00; m_run_len = 0;
    m_valid = 1'b0; m_code = 3'd0; m_multi = 1'b0; m_ovr = 1'b0;
  endtask

  // A pattern commits once the synchronised value has been seen
  // unchanged on CM+2 consecutive edges and differs from the last one.
  task automatic model_step();
    logic [7:0] seen;
    logic       ev;
    ev = 1'b0;
    seen = m_s2;
    if (seen == m_run_val) begin
      if (m_run_len < 1000) m_run_len++;
    end else begin
      m_run_val = seen;
      m_run_len = 1;
    end
    if (m_run_len >= CM + 2 && m_run_val != m_stable) begin
      ev = (m_run_val != 8'h00);
      m_stable = m_run_val;
    end
    if (ev) begin
      for (int i = 0; i < 8; i++)
        if (m_run_val[i]) m_code = 3'(i);
      m_multi = ($countones(m_run_val) > 1);
      m_ovr = m_valid && !out_ready;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end
    m_s2 = m_s1;
    m_s1 = in;
  endtask

  task automatic cmp_model();
    chk("m_valid", 8'(out_valid), 8'(m_valid));
    chk("m_code", 8'(code), 8'(m_code));
    chk("m_multi", 8'(multi), 8'(m_multi));
    chk("m_overrun", 8'(overrun), 8'(m_ovr));
  endtask

  task automatic tick();
    if (sys_rst) model_reset();
    else model_step();
    @(posedge sys_clk);
    #1;
    cmp_model();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_ev(input string tag, input logic [2:0] c,
                        input logic mu, input logic ov);
    chk({tag, "_valid"}, 8'(out_valid), 8'd1);
    chk({tag, "_code"}, 8'(code), 8'(c));
    chk({tag, "_multi"}, 8'(multi), 8'(mu));
    chk({tag, "_overrun"}, 8'(overrun), 8'(ov));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sys_rst = 1'b1;
    in = 8'h00;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_code", 8'(code), 8'd0);
    chk("rst_multi", 8'(multi), 8'd0);
    chk("rst_overrun", 8'(overrun), 8'd0);
    ticks(3);
    sys_rst = 1'b0;
    ticks(2);

    // 1: single key
    in = 8'h20;
    ticks(6);
    chk("t1_early", 8'(out_valid), 8'd0);
    tick();
    chk_ev("t1", 3'd5, 1'b0, 1'b0);
    accept();
    chk("t1_acc", 8'(out_valid), 8'd0);
    in = 8'h00;
    ticks(10);

    // 2: bouncing bit 3
    for (int k = 0; k < 6; k++) begin
      in = (k % 2 == 0) ? 8'h08 : 8'h00;
      ticks(2);
      chk("t2_bounce", 8'(out_valid), 8'd0);
    end
    in = 8'h08;
    ticks(6);
    chk("t2_early", 8'(out_valid), 8'd0);
    tick();
    chk_ev("t2", 3'd3, 1'b0, 1'b0);
    accept();
    in = 8'h00;
    ticks(10);
    chk("t2_release", 8'(out_valid), 8'd0);

    // 3: multi-bit pattern
    in = 8'h89;
    ticks(7);
    chk_ev("t3", 3'd7, 1'b1, 1'b0);
    accept();
    in = 8'h00;
    ticks(10);

    // 4: short pulses
    in = 8'h10;
    ticks(2);
    in = 8'h00;
    ticks(10);
    chk("t4_pulse", 8'(out_valid), 8'd0);
    in = 8'h10;
    ticks(7);
    chk_ev("t4", 3'd4, 1'b0, 1'b0);
    accept();
    in = 8'h30;
    tick();
    in = 8'h10;
    ticks(10);
    chk("t4_glitch", 8'(out_valid), 8'd0);
    in = 8'h00;
    ticks(10);

    // 5: overrun and same-edge accept
    in = 8'h04;
    ticks(7);
    chk_ev("t5a", 3'd2, 1'b0, 1'b0);
    in = 8'h00;
    ticks(7);
    in = 8'h02;
    ticks(7);
    chk_ev("t5b", 3'd1, 1'b0, 1'b1);
    accept();
    chk("t5_acc_valid", 8'(out_valid), 8'd0);
    chk("t5_acc_ovr", 8'(overrun), 8'd0);
    in = 8'h00;
    ticks(10);
    in = 8'h04;
    ticks(7);
    in = 8'h00;
    ticks(7);
    in = 8'h80;
    ticks(6);
    accept();
    chk_ev("t5c", 3'd7, 1'b0, 1'b0);
    accept();
    in = 8'h00;
    ticks(10);

    // 6: reset during settle with an event pending
    in = 8'h02;
    ticks(7);
    in = 8'h40;
    ticks(4);
    sys_rst = 1'b1;
    model_reset();
    #1;
    chk("t6_valid", 8'(out_valid), 8'd0);
    chk("t6_code", 8'(code), 8'd0);
    chk("t6_multi", 8'(multi), 8'd0);
    chk("t6_overrun", 8'(overrun), 8'd0);
    ticks(2);
    sys_rst = 1'b0;
    ticks(6);
    chk("t6_early", 8'(out_valid), 8'd0);
    tick();
    chk_ev("t6", 3'd6, 1'b0, 1'b0);
    accept();

    // random bouncing patterns, random ready, rare resets
    begin
      int hold;
      logic [7:0] one;
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
        if (hold == 0) begin
          case ($urandom_range(0, 3))
            0: in = 8'h00;
            1: begin
              one = 8'h01;
              in = one << $urandom_range(0, 7);
            end
            default: in = 8'($urandom);
          endcase
          hold = $urandom_range(1, 10);
        end
        hold--;
        out_ready = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 299) == 0) begin
          sys_rst = 1'b1;
          model_reset();
          #1;
          cmp_model();
          tick();
          sys_rst = 1'b0;
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encoder8_3_deb.md
# encoder8_3_deb

Debounced 8-to-3 priority encoder: the input-side counterpart of the team's 3-to-8 decoder. It synchronises eight raw active-high lines (keys, DIP switches, one-hot strobes) and debounces them as one pattern. Each new stable non-zero pattern is encoded to a 3-bit index of the highest set bit and presented on a valid/ready handshake for downstream logic (for example, a decoder driving LEDs).

## Interface
- CNT_MAX, default 999_999: stable cycles minus one required to commit a pattern (20 ms at 50 MHz); legal range 1 to 2^20-1.
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- in  input  8  raw asynchronous lines, bit i has priority i (7 highest)
- out_ready  input  1  consumer accepts the current event
- out_valid  output  1  event pending; held until accepted
- code  output  3  index of the highest set bit of the committed pattern
- multi  output  1  committed pattern had more than one bit set
- overrun  output  1  a pending event was overwritten before acceptance; sticky

## Operation
- Synchroniser: 2 flops per bit (in_s1, in_s2); reset value 8'h00.
- Registers:
  - stable_pat[7:0], reset 8'h00: last committed pattern.
  - cand[7:0]: candidate pattern.
  - cnt: 20-bit counter.
  - State: IDLE or SETTLE.
- IDLE: if in_s2 != stable_pat, load cand=in_s2, cnt=0 and go to SETTLE.
- SETTLE behaviour:
  - If in_s2 != cand: reload cand=in_s2, cnt=0 and stay in SETTLE. Any bounce restarts the count.
  - Else if cnt == CNT_MAX: commit. Set stable_pat=cand and go to IDLE.
  - Else: cnt+1.
- Commit generates an event only if cand != 0 and cand != old stable_pat. Otherwise (release to zero, or return to the previous pattern) it is silent.
- Event:
  - code = position of the highest '1' in cand.
  - multi = popcount(cand) > 1.
  - out_valid = 1.
  - All three are registered at the commit edge.
- Handshake and event interactions:
  - Transfer occurs on an edge with out_valid && out_ready.
  - Transfer alone: out_valid becomes 0 and overrun becomes 0. code and multi keep their last values.
  - Event while out_valid=1 and out_ready=0: code and multi are overwritten, out_valid stays 1, overrun becomes 1.
  - Event on the same edge as a transfer: the new event is loaded, out_valid stays 1, overrun becomes 0.
- Reset values: out_valid=0, code=3'd0, multi=0, overrun=0, state IDLE, cnt=0, cand=8'h00.
- Reset mid-SETTLE or with an event pending drops everything. A line still held after release is seen as a change from 8'h00 and produces a fresh event.

## Timing
- Edge 0 is the first rising edge after `in` changes and stays constant:
  - in_s2 is valid after edge 1.
  - SETTLE is entered at edge 2.
  - cnt reaches CNT_MAX at edge 2+CNT_MAX.
  - Commit happens at edge 3+CNT_MAX; out_valid is high from then on.
- Latency from the input change to out_valid is CNT_MAX+4 cycles. No combinational path from `in` or out_ready to any output.
- Throughput is at most one event per CNT_MAX+2 cycles. Events need not wait for acceptance (see overrun).
- out_valid must not drop without a transfer or a reset. code and multi are stable while out_valid=1, except on an overwrite.
- Counter never wraps: it is cleared on entry to SETTLE and saturates at the compare.

## Test plan
Benches use CNT_MAX=3.
1. Reset, then in=8'h20 held: out_valid=1 after edge 6 with code=5, multi=0, overrun=0. out_ready pulsed for 1 cycle: out_valid=0 next edge.
2. Bit 3 toggled every 2 cycles for 12 cycles, then held at 8'h08: exactly one event, code=3, 7 cycles after the last toggle. Release to 8'h00: no event.
3. in=8'h89 held: code=7, multi=1.
4. Pattern changes and reverts within CNT_MAX cycles:
   - 8'h00 to 8'h10 and back to 8'h00 within 2 cycles: out_valid stays 0.
   - 8'h10 committed and accepted, then a 1-cycle glitch to 8'h30: no second event.
5. out_ready=0 throughout:
   - Press 8'h04, release, press 8'h02: code=1, overrun=1, out_valid=1.
   - Then out_ready=1 for 1 cycle: out_valid=0, overrun=0.
   - Separate case: commit coinciding with acceptance gives out_valid=1, overrun=0, with the new code.
6. sys_rst pulsed during SETTLE with in=8'h40 held:
   - All outputs are 0 while reset is asserted.
   - After release, out_valid rises CNT_MAX+4 cycles later with code=6.
